biriscv_ras_ckpt: RTL

Parametrised return-address stack with speculative checkpoint/restore, sitting beside the next-PC logic in the fetch stage. It keeps a speculative stack driven by fetch-time call/return predictions and a committed stack driven by retired calls/returns. It repairs the speculative stack on mispredict from a per-branch checkpoint, or wholesale from the committed copy on flush. Replaces the fixed 8-entry, index-only RAS recovery.

---
 rtl/biriscv_ras_ckpt.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/biriscv_ras_ckpt.sv
// Return-address stack with speculative checkpoint/restore for the fetch-stage next-PC logic.
// Latency: every update is registered; pred_pc_o/pred_valid_o show an op or recovery one cycle later.
// Backpressure: no internal stall; an allocation while ckpt_full_o is high is dropped, so upstream must stall.
//
// Ports:
//   clk_i, rst_i                        clock, synchronous active-low reset
//   spec_push_i/spec_pop_i/spec_push_pc_i  fetch-time predicted call/return
//   spec_ckpt_i, spec_ckpt_id_o, ckpt_full_o  checkpoint allocation and its slot id
//   ckpt_release_i                      oldest checkpointed branch resolved correctly
//   recover_i, recover_ckpt_i           mispredict repair from a checkpoint slot
//   flush_i                             copy committed stack into speculative stack
//   commit_push_i/commit_pop_i/commit_push_pc_i  retired call/return
//   pred_pc_o, pred_valid_o             speculative top of stack and non-empty flag
module biriscv_ras_ckpt #(
  parameter int DEPTH    = 8,
  parameter int DEPTH_W  = 3,
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spec_push_i,
  input  logic              spec_pop_i,
  input  logic [ADDR_W-1:0] spec_push_pc_i,
  input  logic              spec_ckpt_i,
  output logic [CKPT_W-1:0] spec_ckpt_id_o,
  output logic              ckpt_full_o,
  input  logic              ckpt_release_i,
  input  logic              recover_i,
  input  logic [CKPT_W-1:0] recover_ckpt_i,
  input  logic              flush_i,
  input  logic              commit_push_i,
  input  logic              commit_pop_i,
  input  logic [ADDR_W-1:0] commit_push_pc_i,
  output logic [ADDR_W-1:0] pred_pc_o,
  output logic              pred_valid_o
);

  localparam int CNT_W = DEPTH_W + 1;

  // Next {tos, count} for one stack given this cycle's push/pop.
  // A push always writes at the returned tos (for push+pop that is the old tos).
  function automatic logic [DEPTH_W+CNT_W-1:0] stk_next(
    input logic [DEPTH_W-1:0] tos,
    input logic [CNT_W-1:0]   cnt,
    input logic               push,
    input logic               pop
  );
    logic [DEPTH_W-1:0] t;
    logic [CNT_W-1:0]   c;
    t = tos;
    c = cnt;
    if (push && pop) begin
      c = (cnt == '0) ? CNT_W'(1) : cnt;
    end else if (push) begin
      t = tos + 1'b1;
      c = (cnt == CNT_W'(DEPTH)) ? cnt : cnt + 1'b1;  // overflow drops the oldest
    end else if (pop && cnt != '0) begin
      t = tos - 1'b1;
      c = cnt - 1'b1;
    end
    return {t, c};
  endfunction

  logic [ADDR_W-1:0]  spec_mem [DEPTH];
  logic [DEPTH_W-1:0] spec_tos;
  logic [CNT_W-1:0]   spec_cnt;
  logic [ADDR_W-1:0]  com_mem  [DEPTH];
  logic [DEPTH_W-1:0] com_tos;
  logic [CNT_W-1:0]   com_cnt;

  logic [DEPTH_W-1:0] ck_tos [NUM_CKPT];
  logic [CNT_W-1:0]   ck_cnt [NUM_CKPT];
  logic [ADDR_W-1:0]  ck_top [NUM_CKPT];
  logic [CKPT_W-1:0]  wr_ptr, rd_ptr;
  logic [CKPT_W:0]    ckpt_occ;

  logic               recover_eff, rel_eff, alloc_eff;
  logic [DEPTH_W-1:0] base_tos, sp_tos_n, com_tos_n;
  logic [CNT_W-1:0]   base_cnt, sp_cnt_n, com_cnt_n;
  logic [CKPT_W-1:0]  rd_n, wr_n, rec_diff;
  logic [CKPT_W:0]    occ_n;

  assign ckpt_full_o    = (ckpt_occ == (CKPT_W+1)'(NUM_CKPT));
  assign spec_ckpt_id_o = wr_ptr;
  assign pred_pc_o      = spec_mem[spec_tos];
  assign pred_valid_o   = (spec_cnt != '0);

  assign recover_eff = recover_i && !flush_i;
  assign rel_eff     = ckpt_release_i && (ckpt_occ != '0) && !flush_i;
  assign alloc_eff   = spec_ckpt_i && !ckpt_full_o && !flush_i && !recover_i;

  // On recovery the spec op of the same cycle lands on top of the restored state.
  assign base_tos = recover_eff ? ck_tos[recover_ckpt_i] : spec_tos;
  assign base_cnt = recover_eff ? ck_cnt[recover_ckpt_i] : spec_cnt;
  assign {sp_tos_n, sp_cnt_n}   = stk_next(base_tos, base_cnt, spec_push_i, spec_pop_i);
  assign {com_tos_n, com_cnt_n} = stk_next(com_tos, com_cnt, commit_push_i, commit_pop_i);

  // Release is applied before the recovery truncates the queue; occupancy is
  // the distance from the surviving oldest slot to the recovered slot.
  assign rd_n     = rd_ptr + CKPT_W'(rel_eff);
  assign rec_diff = recover_ckpt_i - rd_n;

  always_comb begin
    wr_n  = wr_ptr;
    occ_n = ckpt_occ;
    if (flush_i) begin
      wr_n  = '0;
      occ_n = '0;
    end else if (recover_eff) begin
      wr_n  = recover_ckpt_i;
      occ_n = {1'b0, rec_diff};
    end else begin
      wr_n = wr_ptr + CKPT_W'(alloc_eff);
      if (alloc_eff && !rel_eff)      occ_n = ckpt_occ + 1'b1;
      else if (!alloc_eff && rel_eff) occ_n = ckpt_occ - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        spec_mem[i] <= '0;
        com_mem[i]  <= '0;
      end
      for (int i = 0; i < NUM_CKPT; i++) begin
        ck_tos[i] <= '0;
        ck_cnt[i] <= '0;
        ck_top[i] <= '0;
      end
      spec_tos <= '0;
      spec_cnt <= '0;
      com_tos  <= '0;
      com_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ckpt_occ <= '0;
    end else begin
      com_tos <= com_tos_n;
      com_cnt <= com_cnt_n;
      if (commit_push_i) com_mem[com_tos_n] <= commit_push_pc_i;

      if (flush_i) begin
        // Copy the committed stack as it stands after this cycle's commit op.
        for (int i = 0; i < DEPTH; i++)
          spec_mem[i] <= (commit_push_i && com_tos_n == DEPTH_W'(i)) ? commit_push_pc_i : com_mem[i];
        spec_tos <= com_tos_n;
        spec_cnt <= com_cnt_n;
      end else begin
        // Restore the saved top first (a push after a pop may have clobbered it);
        // a push in the same cycle then overrides it if it hits the same entry.
        if (recover_eff) spec_mem[ck_tos[recover_ckpt_i]] <= ck_top[recover_ckpt_i];
        if (spec_push_i) spec_mem[sp_tos_n] <= spec_push_pc_i;
        spec_tos <= sp_tos_n;
        spec_cnt <= sp_cnt_n;
      end

      // Snapshot is the state before this cycle's spec op.
      if (alloc_eff) begin
        ck_tos[wr_ptr] <= spec_tos;
        ck_cnt[wr_ptr] <= spec_cnt;
        ck_top[wr_ptr] <= spec_mem[spec_tos];
      end

      rd_ptr   <= flush_i ? '0 : rd_n;
      wr_ptr   <= wr_n;
      ckpt_occ <= occ_n;
    end
  end

endmodule
